// File: rtl/alu_op_issue.sv
// alu_op_issue: RV64I OP/OP-IMM decode and issue into an ID/EX register with a 2-entry skid buffer.
// Optional ALU_OP_COUNT_EN adds issue_cnt/illegal_cnt output-transfer counters.
module alu_op_issue #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [XLEN-1:0]  rs1_data,
   input  logic [XLEN-1:0]  rs2_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  alu_rs1,
   output logic [XLEN-1:0]  alu_rs2,
   output logic [3:0]       alu_control,
   output logic [4:0]       rd_addr,
   output logic             illegal
`ifdef ALU_OP_COUNT_EN
  ,output logic [CNT_W-1:0] issue_cnt,
   output logic [CNT_W-1:0] illegal_cnt
`endif
);
   localparam int EW = 10 + 2 * XLEN;
   localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_XOR = 4'b0011,
                          C_SLL = 4'b0100, C_SRL = 4'b0101, C_SUB = 4'b0110, C_SRA = 4'b0111,
                          C_SLT = 4'b1000, C_SLTU = 4'b1001;

   logic [2:0]      w_f3;
   logic [6:0]      w_f7;
   logic [5:0]      w_f6;
   logic            w_is_r, w_is_i, w_shift, w_alt, w_legal;
   logic [3:0]      w_base, w_code;
   logic [XLEN-1:0] w_op_a, w_op_b;
   logic [EW-1:0]   w_dec;
   logic            w_in_fire, w_load_out, w_unused;
   logic            r_out_valid, r_skid_valid;
   logic [EW-1:0]   r_out, r_skid;

   assign w_f3    = instr[14:12];
   assign w_f7    = instr[31:25];
   assign w_f6    = instr[31:26];
   assign w_is_r  = instr[6:0] == 7'b0110011;
   assign w_is_i  = instr[6:0] == 7'b0010011;
   assign w_shift = w_f3[1:0] == 2'b01;
   assign w_unused = ^instr[19:15] ^ (CNT_W == 0);

   always_comb begin
      w_base = C_AND;
      case (w_f3)
         3'b000:  w_base = C_ADD;
         3'b001:  w_base = C_SLL;
         3'b010:  w_base = C_SLT;
         3'b011:  w_base = C_SLTU;
         3'b100:  w_base = C_XOR;
         3'b101:  w_base = C_SRL;
         3'b110:  w_base = C_OR;
         default: w_base = C_AND;
      endcase
   end

   // funct7 0100000 selects SUB/SRA on R-type; only SRAI uses the alternate encoding on I-type
   assign w_alt   = w_is_r ? (w_f7 == 7'b0100000) : (w_f3 == 3'b101 && w_f6 == 6'b010000);
   assign w_legal = w_is_r ? (w_f7 == 7'b0 || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)))
                  : w_is_i ? (!w_shift || w_f6 == 6'b0 || (w_f6 == 6'b010000 && w_f3 == 3'b101))
                  : 1'b0;
   assign w_code  = !w_legal ? C_ADD : w_alt ? (w_f3 == 3'b000 ? C_SUB : C_SRA) : w_base;
   assign w_op_a  = w_legal ? rs1_data : '0;
   assign w_op_b  = !w_legal ? '0 : w_is_r ? rs2_data
                  : w_shift ? {{(XLEN-6){1'b0}}, instr[25:20]}
                  : {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign w_dec   = {!w_legal, w_code, instr[11:7], w_op_a, w_op_b};

   assign w_in_fire  = in_valid && !r_skid_valid;
   assign w_load_out = !r_out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_out        <= '0;
         r_skid       <= '0;
      end else if (flush) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_load_out) begin
         r_out_valid  <= r_skid_valid || w_in_fire;
         r_skid_valid <= 1'b0;
         if (r_skid_valid) r_out <= r_skid;
         else if (w_in_fire) r_out <= w_dec;
      end else if (w_in_fire) begin
         r_skid_valid <= 1'b1;
         r_skid       <= w_dec;
      end
   end

   assign in_ready  = !r_skid_valid;
   assign out_valid = r_out_valid;
   assign {illegal, alu_control, rd_addr, alu_rs1, alu_rs2} = r_out;

`ifdef ALU_OP_COUNT_EN
   logic [CNT_W-1:0] r_issue_cnt, r_illegal_cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_issue_cnt   <= '0;
         r_illegal_cnt <= '0;
      end else if (r_out_valid && out_ready) begin
         if (illegal) r_illegal_cnt <= r_illegal_cnt + 1'b1;
         else r_issue_cnt <= r_issue_cnt + 1'b1;
      end
   end
   assign issue_cnt   = r_issue_cnt;
   assign illegal_cnt = r_illegal_cnt;
`endif
endmodule

// File: tb/tb_alu_op_issue.sv
// tb_alu_op_issue: directed and random checks of alu_op_issue against a queue-based reference model.
module tb_alu_op_issue;
   typedef struct packed {
      logic        ill;
      logic [3:0]  c;
      logic [4:0]  rd;
      logic [63:0] a;
      logic [63:0] b;
   } ent_t;

   logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] instr = '0;
   logic [63:0] rs1_data = '0, rs2_data = '0;
   logic        in_ready, out_valid, illegal;
   logic [63:0] alu_rs1, alu_rs2;
   logic [3:0]  alu_control;
   logic [4:0]  rd_addr;
   int          total = 0, bad = 0;
   ent_t        q[$];
   logic [31:0] m_iss = '0, m_ill = '0;
`ifdef ALU_OP_COUNT_EN
   logic [31:0] issue_cnt, illegal_cnt;
`endif

   alu_op_issue dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid),
      .out_ready(out_ready), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_control(alu_control),
      .rd_addr(rd_addr), .illegal(illegal)
`ifdef ALU_OP_COUNT_EN
     ,.issue_cnt(issue_cnt), .illegal_cnt(illegal_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic ent_t model(logic [31:0] ins, logic [63:0] a, logic [63:0] b);
      ent_t e;
      logic [63:0] imm;
      logic [3:0]  c;
      logic        ok;
      imm = {{52{ins[31]}}, ins[31:20]};
      c = 4'd2;
      ok = 1'b1;
      if (ins[6:0] == 7'h33) begin
         case ({ins[31:25], ins[14:12]})
            {7'h00, 3'd0}: c = 4'd2;  {7'h20, 3'd0}: c = 4'd6;
            {7'h00, 3'd1}: c = 4'd4;  {7'h00, 3'd2}: c = 4'd8;
            {7'h00, 3'd3}: c = 4'd9;  {7'h00, 3'd4}: c = 4'd3;
            {7'h00, 3'd5}: c = 4'd5;  {7'h20, 3'd5}: c = 4'd7;
            {7'h00, 3'd6}: c = 4'd1;  {7'h00, 3'd7}: c = 4'd0;
            default: ok = 1'b0;
         endcase
      end else if (ins[6:0] == 7'h13) begin
         case (ins[14:12])
            3'd0: c = 4'd2;  3'd2: c = 4'd8;  3'd3: c = 4'd9;
            3'd4: c = 4'd3;  3'd6: c = 4'd1;  3'd7: c = 4'd0;
            3'd1: begin c = 4'd4; ok = ins[31:26] == 6'h00; imm = {58'd0, ins[25:20]}; end
            default: begin
               c = ins[31:26] == 6'h10 ? 4'd7 : 4'd5;
               ok = ins[31:26] == 6'h00 || ins[31:26] == 6'h10;
               imm = {58'd0, ins[25:20]};
            end
         endcase
         b = imm;
      end else ok = 1'b0;
      e.ill = !ok;
      e.c   = ok ? c : 4'd2;
      e.rd  = ins[11:7];
      e.a   = ok ? a : 64'd0;
      e.b   = ok ? b : 64'd0;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
      chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
      if (q.size() > 0) begin
         chk("illegal", {63'd0, illegal}, {63'd0, q[0].ill});
         chk("alu_control", {60'd0, alu_control}, {60'd0, q[0].c});
         chk("rd_addr", {59'd0, rd_addr}, {59'd0, q[0].rd});
         chk("alu_rs1", alu_rs1, q[0].a);
         chk("alu_rs2", alu_rs2, q[0].b);
      end
`ifdef ALU_OP_COUNT_EN
      chk("issue_cnt", {32'd0, issue_cnt}, {32'd0, m_iss});
      chk("illegal_cnt", {32'd0, illegal_cnt}, {32'd0, m_ill});
`endif
   endtask

   task automatic step(input logic iv, input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                       input logic ordy, input logic fl);
      logic of, inf;
      in_valid = iv; instr = ins; rs1_data = a; rs2_data = b; out_ready = ordy; flush = fl;
      of  = q.size() > 0 && ordy;
      inf = iv && q.size() < 2;
      @(posedge clk);
      if (of) begin
         if (q[0].ill) m_ill++;
         else m_iss++;
      end
      if (fl) q.delete();
      else begin
         if (of) void'(q.pop_front());
         if (inf) q.push_back(model(ins, a, b));
      end
      @(negedge clk);
      check_all();
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [31:0] w;
      int k;
      w = $urandom;
      k = $urandom_range(0, 9);
      w[6:0] = k < 4 ? 7'h33 : k < 8 ? 7'h13 : w[6:0];
      k = $urandom_range(0, 2);
      if (w[6:0] == 7'h33) w[31:25] = k == 0 ? 7'h00 : k == 1 ? 7'h20 : w[31:25];
      if (w[6:0] == 7'h13 && w[13:12] == 2'b01) w[31:26] = k == 0 ? 6'h00 : k == 1 ? 6'h10 : w[31:26];
      return w;
   endfunction

   initial begin
      #1;
      check_all();
      chk("rst_alu_rs1", alu_rs1, 64'd0);
      chk("rst_ctrl", {60'd0, alu_control}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 32'h002081B3, 64'h5, 64'h7, 1, 0);
      chk("add_ctrl", {60'd0, alu_control}, 64'b0010);
      chk("add_rs2", alu_rs2, 64'h7);
      chk("add_rd", {59'd0, rd_addr}, 64'd3);
      step(1, 32'h402081B3, 64'h9, 64'h4, 1, 0);
      chk("sub_ctrl", {60'd0, alu_control}, 64'b0110);
      step(1, 32'h43F35293, 64'h123, 64'h0, 1, 0);
      chk("srai_ctrl", {60'd0, alu_control}, 64'b0111);
      chk("srai_rs2", alu_rs2, 64'h3F);
      chk("srai_rd", {59'd0, rd_addr}, 64'd5);
      step(1, 32'hFFF00093, 64'h0, 64'h55, 1, 0);
      chk("addi_rs2", alu_rs2, 64'hFFFFFFFFFFFFFFFF);
      step(0, 32'h0, 64'h0, 64'h0, 1, 0);
      step(1, 32'h002081B3, 64'h11, 64'h22, 0, 0);
      step(1, 32'h402081B3, 64'h33, 64'h44, 0, 0);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      step(1, 32'h0020C1B3, 64'h55, 64'h66, 0, 0);
      chk("bp_hold_rs1", alu_rs1, 64'h11);
      step(0, 32'h0, 64'h0, 64'h0, 1, 0);
      chk("bp_second", alu_rs1, 64'h33);
      step(0, 32'h0, 64'h0, 64'h0, 1, 0);
      chk("bp_drained", {63'd0, in_ready}, 64'd1);
      step(1, 32'h0000007F, 64'h7, 64'h8, 1, 0);
      chk("ill_flag", {63'd0, illegal}, 64'd1);
      chk("ill_rs1", alu_rs1, 64'd0);
      step(1, 32'h202081B3, 64'h7, 64'h8, 1, 0);
      chk("ill2_ctrl", {60'd0, alu_control}, 64'b0010);
`ifdef ALU_OP_COUNT_EN
      step(0, 32'h0, 64'h0, 64'h0, 1, 0);
      chk("ill_cnt2", {32'd0, illegal_cnt}, 64'd2);
`endif
      step(1, 32'h002081B3, 64'h1, 64'h2, 0, 0);
      step(1, 32'h002081B3, 64'h3, 64'h4, 0, 0);
      step(1, 32'h002081B3, 64'h5, 64'h6, 0, 1);
      chk("flush_valid", {63'd0, out_valid}, 64'd0);
      chk("flush_ready", {63'd0, in_ready}, 64'd1);
      step(0, 32'h0, 64'h0, 64'h0, 1, 0);
      step(0, 32'h0, 64'h0, 64'h0, 1, 0);
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 3) != 0, rnd_instr(), {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
      step(1, 32'h002081B3, 64'h9, 64'h9, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      m_iss = '0;
      m_ill = '0;
      chk("arst_valid", {63'd0, out_valid}, 64'd0);
      chk("arst_ready", {63'd0, in_ready}, 64'd1);
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 32'h0, 64'h0, 64'h0, 1, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
